// File: rtl/inst_loader_pkg.sv
// Shared defines for the instruction loader: core widths, stream length width
// and the loader state encoding.
package inst_loader_pkg;

  localparam int DEF_CPU_WIDTH    = 32;
  localparam int DEF_REG_WIDTH    = 32;
  localparam int LOADER_LEN_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_e;

  // States in which the loader accepts stream bytes.
  function automatic logic is_rx_state(input loader_state_e s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/inst_loader_word_assembler.sv
// Packs stream bytes little-endian into 32-bit words. word/word_valid are
// presented in the same cycle as the fourth byte's transfer so the parent can
// register the memory write at that very edge.
module word_assembler
  import inst_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     byte_fire,
  input  logic [7:0]               byte_data,
  output logic [DEF_CPU_WIDTH-1:0] word,
  output logic                     word_valid
);

  logic [1:0]               cnt_q, cnt_d;
  logic [DEF_CPU_WIDTH-1:0] shift_q, shift_d;

  // Shift each byte in from the top so byte 0 ends up in bits [7:0].
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_fire) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {byte_data, shift_q[DEF_CPU_WIDTH-1:8]};
    end
  end

  // Byte counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign word       = {byte_data, shift_q[DEF_CPU_WIDTH-1:8]};
  assign word_valid = byte_fire && !clr && (cnt_q == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Boot-time instruction loader: receives a length-prefixed byte stream, writes
// the packed words to instruction memory from address 0, then enables the core.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int CPU_WIDTH  = DEF_CPU_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [CPU_WIDTH-1:0]  mem_wdata,
  output logic                  cpu_ena,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // One extra bit so a full-memory load (N = 2^ADDR_WIDTH) counts cleanly.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  loader_state_e               state_q, state_d;
  logic [LOADER_LEN_WIDTH-1:0] len_q, len_d;
  logic [CNT_W-1:0]            wcnt_q, wcnt_d;
  logic                        wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]       waddr_q, waddr_d;
  logic [CPU_WIDTH-1:0]        wdata_q, wdata_d;
  logic                        byte_ready_q, byte_ready_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        cpu_ena_q, cpu_ena_d;

  logic                        byte_fire;
  logic                        data_fire;
  logic                        asm_clr;
  logic                        word_valid;
  logic [CPU_WIDTH-1:0]        word;
  logic [LOADER_LEN_WIDTH-1:0] len_full;
  logic                        len_too_big;
  logic                        last_word;

  assign byte_fire   = byte_valid && byte_ready_q;
  assign data_fire   = byte_fire && (state_q == ST_DATA);
  assign len_full    = {byte_data, len_q[7:0]};
  assign len_too_big = 32'(len_full) > (32'd1 << ADDR_WIDTH);
  assign last_word   = (32'(wcnt_q) + 32'd1) == 32'(len_q);

  word_assembler u_word_assembler (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (asm_clr),
    .byte_fire  (data_fire),
    .byte_data  (byte_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Next-state logic, write strobe and status flags derived from the next state
  // so that every output is a plain register.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    asm_clr = 1'b0;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (byte_fire) begin
          len_d[7:0] = byte_data;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (byte_fire) begin
          len_d = len_full;
          if (len_full == '0) begin
            state_d = ST_DONE;
          end else if (len_too_big) begin
            state_d = ST_ERR;
          end else begin
            wcnt_d  = '0;
            asm_clr = 1'b1;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_valid) begin
          wen_d   = 1'b1;
          waddr_d = wcnt_q[ADDR_WIDTH-1:0];
          wdata_d = word;
          wcnt_d  = wcnt_q + CNT_ONE;
          if (last_word) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    byte_ready_d = is_rx_state(state_d);
    busy_d       = is_rx_state(state_d) || (state_d == ST_FLUSH);
    done_d       = (state_d == ST_DONE);
    err_d        = (state_d == ST_ERR);
    cpu_ena_d    = (state_d == ST_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      wcnt_q       <= '0;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cpu_ena_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wcnt_q       <= wcnt_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cpu_ena_q    <= cpu_ena_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_wen    = wen_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_ena    = cpu_ena_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed and randomized loads compared
// against a byte-stream reference model.
module tb_inst_loader;

  localparam int AW = 8;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic          mem_wen;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          cpu_ena;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] obs_addr[$];
  logic [31:0]   obs_data[$];

  always #5 clk = ~clk;

  inst_loader #(.ADDR_WIDTH(AW), .CPU_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_ena    (cpu_ena),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Record every memory write strobe.
  always @(negedge clk) begin
    if (mem_wen === 1'b1) begin
      obs_addr.push_back(mem_waddr);
      obs_data.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic byte_q_t make_stream(input int n, input int kind);
    byte_q_t q;
    logic [31:0] w;
    logic [15:0] nn;
    nn = n[15:0];
    q.push_back(nn[7:0]);
    q.push_back(nn[15:8]);
    if (n <= (1 << AW)) begin
      for (int i = 0; i < n; i++) begin
        w = (kind == 1) ? 32'(i) : $urandom();
        for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
      end
    end
    return q;
  endfunction

  task automatic do_start(output int edges);
    obs_addr.delete();
    obs_data.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
  endtask

  // mode 0: full rate, 1: valid every other cycle, 2: random stalls
  task automatic run_stream(input byte_q_t q, input int mode, input bit poke, inout int edges);
    int idx = 0;
    int guard = 0;
    int limit = 8 * q.size() + 50;
    bit v;
    bit fired;
    while (idx < q.size() && guard < limit) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      byte_valid = v;
      byte_data  = v ? q[idx] : 8'($urandom());
      start      = poke && ($urandom_range(0, 7) == 0);
      fired      = v && (byte_ready === 1'b1);
      @(negedge clk);
      edges++;
      guard++;
      if (fired) idx++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    if (idx < q.size()) chk("stream_timeout", 64'(idx), 64'(q.size()));
  endtask

  // Reference model: N from the header, word i from bytes 2+4i..5+4i little-endian.
  task automatic check_load(input string tag, input byte_q_t q, input int mode, inout int edges);
    int n;
    int nw;
    int g = 0;
    bit bad;
    logic [31:0] ew;
    n   = int'(q[0]) + 256 * int'(q[1]);
    bad = n > (1 << AW);
    nw  = bad ? 0 : n;
    while (cpu_ena !== 1'b1 && err !== 1'b1 && g < 20) begin
      @(negedge clk);
      edges++;
      g++;
    end
    if (bad) begin
      chk({tag, "_err"}, 64'(err), 64'd1);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_cpu_ena"}, 64'(cpu_ena), 64'd0);
      chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    end else begin
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_cpu_ena"}, 64'(cpu_ena), 64'd1);
      chk({tag, "_err"}, 64'(err), 64'd0);
      chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    end
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_write_count"}, 64'(obs_addr.size()), 64'(nw));
    for (int i = 0; i < nw && i < obs_addr.size(); i++) begin
      ew = 32'(q[2+4*i]) + (32'(q[3+4*i]) << 8) + (32'(q[4+4*i]) << 16) + (32'(q[5+4*i]) << 24);
      chk($sformatf("%s_waddr[%0d]", tag, i), 64'(obs_addr[i]), 64'(i));
      chk($sformatf("%s_wdata[%0d]", tag, i), 64'(obs_data[i]), 64'(ew));
    end
    if (mode == 0) chk({tag, "_edges"}, 64'(edges), (n == 0 || bad) ? 64'd3 : 64'(4 * n + 4));
    $display("load %s N=%0d mode=%0d writes=%0d done=%0b err=%0b", tag, n, mode,
             obs_addr.size(), done, err);
  endtask

  initial begin
    byte_q_t s;
    byte_q_t part;
    int e;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_byte_ready", 64'(byte_ready), 64'd0);
    chk("rst_mem_wen", 64'(mem_wen), 64'd0);
    chk("rst_cpu_ena", 64'(cpu_ena), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_waddr", 64'(mem_waddr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_byte_ready", 64'(byte_ready), 64'd0);
    chk("idle_cpu_ena", 64'(cpu_ena), 64'd0);

    // Directed N=2 stream at full rate, then with toggling valid
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    do_start(e);
    run_stream(s, 0, 1'b0, e);
    check_load("n2_full", s, 0, e);
    if (obs_data.size() == 2) begin
      chk("n2_word0", 64'(obs_data[0]), 64'h00100513);
      chk("n2_word1", 64'(obs_data[1]), 64'h00200593);
    end else chk("n2_nwrites", 64'(obs_data.size()), 64'd2);
    do_start(e);
    run_stream(s, 1, 1'b0, e);
    check_load("n2_toggle", s, 1, e);

    // N=0
    s = make_stream(0, 0);
    do_start(e);
    run_stream(s, 0, 1'b0, e);
    check_load("n0", s, 0, e);

    // start in DONE drops enable and done on the next edge
    do_start(e);
    chk("restart_cpu_ena", 64'(cpu_ena), 64'd0);
    chk("restart_done", 64'(done), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    chk("restart_byte_ready", 64'(byte_ready), 64'd1);
    s = make_stream(1, 0);
    run_stream(s, 2, 1'b0, e);
    check_load("restart_n1", s, 2, e);

    // N=257 is rejected; further bytes are not consumed
    s = make_stream(257, 0);
    do_start(e);
    run_stream(s, 0, 1'b0, e);
    check_load("n257", s, 0, e);
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    chk("n257_hold_writes", 64'(obs_addr.size()), 64'd0);
    chk("n257_hold_err", 64'(err), 64'd1);
    s = make_stream(1, 0);
    do_start(e);
    chk("err_clear", 64'(err), 64'd0);
    run_stream(s, 0, 1'b0, e);
    check_load("after_err", s, 0, e);

    // Full memory: N=256 incrementing words
    s = make_stream(256, 1);
    do_start(e);
    run_stream(s, 0, 1'b0, e);
    check_load("n256", s, 0, e);
    if (obs_addr.size() == 256) begin
      chk("n256_last_addr", 64'(obs_addr[255]), 64'hFF);
      chk("n256_last_data", 64'(obs_data[255]), 64'hFF);
    end

    // Asynchronous reset after 5 data bytes of an N=2 load
    s = make_stream(2, 0);
    part = s[0:6];
    do_start(e);
    run_stream(part, 0, 1'b0, e);
    chk("midrst_first_write", 64'(obs_addr.size()), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_byte_ready", 64'(byte_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_mem_wen", 64'(mem_wen), 64'd0);
    chk("midrst_waddr", 64'(mem_waddr), 64'd0);
    chk("midrst_wdata", 64'(mem_wdata), 64'd0);
    chk("midrst_status", 64'({cpu_ena, done, err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(e);
    run_stream(s, 0, 1'b0, e);
    check_load("after_rst", s, 0, e);

    // Randomized loads with stalls and ignored start pulses
    for (int t = 0; t < 10; t++) begin
      int n;
      int m;
      n = $urandom_range(1, 12);
      m = $urandom_range(0, 2);
      s = make_stream(n, 0);
      do_start(e);
      run_stream(s, m, 1'b1, e);
      check_load($sformatf("rand%0d", t), s, m, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time instruction loader that fills the core's instruction memory from a byte stream. It holds the core's program-counter enable low, accepts a length-prefixed byte stream over a valid/ready handshake, and packs bytes little-endian into 32-bit words. It writes each word to consecutive instruction-memory addresses, then raises the enable so the core starts fetching from address 0. It is the write side of the instruction memory that the core's fetch path only reads.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: instruction-memory word-address width; depth = 2^ADDR_WIDTH words.
- `CPU_WIDTH`, default 32 (from shared defines): instruction word width; fixed at 32.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock.
  - `rst_n`  in  1  asynchronous active-low reset.
- Control:
  - `start`  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- Byte stream:
  - `byte_valid`  in  1  the source presents `byte_data`.
  - `byte_data`  in  8  stream byte.
  - `byte_ready`  out  1  the loader accepts a byte this cycle.
- Memory write:
  - `mem_wen`  out  1  one-cycle instruction-memory write strobe.
  - `mem_waddr`  out  ADDR_WIDTH  word address.
  - `mem_wdata`  out  32  instruction word.
- Status:
  - `cpu_ena`  out  1  core enable; low while loading or in error.
  - `busy`  out  1  high in LEN_LO, LEN_HI, DATA and FLUSH.
  - `done`  out  1  level; the last load completed.
  - `err`  out  1  level; the last load was rejected.

## Operation
- Stream format:
  - Two bytes form a 16-bit word count N, low byte first.
  - N×4 data bytes follow.
  - Byte k of a word goes to bits [8k+7:8k].
- Transfer rule: a byte transfers on a rising edge where `byte_valid && byte_ready`. `byte_ready` is a registered output, high only in LEN_LO, LEN_HI and DATA.
- IDLE (state after reset): `cpu_ena`=0, `done`=0, `err`=0. On `start`, go to LEN_LO.
- LEN_LO: on transfer, latch N[7:0] and go to LEN_HI.
- LEN_HI: on transfer, latch N[15:8], then:
  - N=0: go to DONE with no writes.
  - N > 2^ADDR_WIDTH: go to ERR.
  - Otherwise: clear the word counter and byte counter, then go to DATA.
- DATA:
  - Each transfer shifts the byte into the word register and increments a 2-bit byte counter.
  - On the fourth byte, register `mem_wen`=1, `mem_wdata`=assembled word and `mem_waddr`=word counter, all for exactly one cycle, then increment the word counter.
  - If that word is word N-1, go to FLUSH. Otherwise stay in DATA.
- FLUSH: one cycle covering the final write strobe, then go to DONE.
- DONE: `done`=1, `cpu_ena`=1. On `start`: clear `done`, drop `cpu_ena`, go to LEN_LO.
- ERR: `err`=1, `cpu_ena`=0, `byte_ready`=0. On `start`: clear `err`, go to LEN_LO.
- Ignored events:
  - `start` in LEN_LO, LEN_HI, DATA or FLUSH is ignored.
  - `byte_valid` while `byte_ready`=0 is ignored; no byte is consumed.
- Address arithmetic: the word counter is ADDR_WIDTH+1 bits, so N = 2^ADDR_WIDTH loads the full memory, with the last address all-ones. `mem_waddr` is the counter's low ADDR_WIDTH bits.

## Timing
- Reset values:
  - State IDLE.
  - `byte_ready`, `mem_wen`, `cpu_ena`, `busy`, `done`, `err` all 0.
  - `mem_waddr`, `mem_wdata` 0.
  - Internal counters 0.
- All outputs are registered; there are no combinational input-to-output paths.
- Stalls: `byte_ready` stays high through source stalls. The maximum rate is one byte per cycle.
- Write latency: `mem_wen` is high in the cycle after the edge that accepted the word's fourth byte.
- Final write and enable: the last write is strobed during FLUSH, and `cpu_ena` rises one edge later. The core therefore never fetches before the last word is committed.
- Load time at full rate: a load of N≥1 words ends with `cpu_ena`=1 after 2+4N+1 edges following the start edge, plus one edge to leave IDLE.
- Reset mid-load: all outputs return to reset values immediately. Words already written stay in memory, and the memory is not cleared.

## Structure
- Put the following in the shared defines, alongside the CPU and register width constants:
  - state encoding (IDLE, LEN_LO, LEN_HI, DATA, FLUSH, DONE, ERR; 3 bits);
  - `LOADER_LEN_WIDTH`=16.
- One natural sub-module: `word_assembler`.
  - Contains the 2-bit byte counter and 32-bit shift register.
  - Inputs: `clk`, `rst_n`, `clr`, `byte_fire`, `byte_data`.
  - Outputs: `word`, `word_valid` (one cycle).
- The FSM, word counter, length register and status flags live in `inst_loader`.

## Test plan
- N=2; bytes 02 00 13 05 10 00 93 05 20 00 at full rate → writes 0x00100513@0, then 0x00200593@1; `cpu_ena` rises the edge after FLUSH; `done`=1.
- Same stream with `byte_valid` toggling every other cycle → identical writes; `mem_wen` strobes exactly two single cycles.
- N=0 (bytes 00 00) → no `mem_wen`; DONE two transfers after start; `cpu_ena`=1.
- ADDR_WIDTH=8, N=257 (01 01) → ERR, `err`=1, `byte_ready`=0, `cpu_ena`=0. N=256 of incrementing words → last write at address 0xFF with word 0x000000FF.
- `rst_n` low after 5 data bytes of an N=2 load → all outputs 0 asynchronously. A subsequent `start` restarts from LEN_LO.
- `start` pulsed mid-DATA → ignored; load completes normally. `start` in DONE → `cpu_ena` and `done` drop on the next edge.
